// File: rtl/ov7670_sccb_config_if.sv
// ov7670_sccb_config_if: SCCB pins of the OV7670 register configurator.
// siod_oe=1 pulls SIOD low; a released SIOD is pulled high externally.
`timescale 1ns/1ps
interface ov7670_sccb_config_if;
  logic sioc;
  logic siod_oe;

  modport master (
    output sioc,
    output siod_oe
  );

  modport slave (
    input sioc,
    input siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: walks a fixed OV7670 register table as SCCB writes.
// Define OV7670_SOFT_RESET_EN to prepend a COM7 soft reset plus settle delay.
`timescale 1ns/1ps
module ov7670_sccb_config #(
  parameter int CLK_DIV      = 125,
  parameter int DELAY_CYCLES = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iniciar,
  ov7670_sccb_config_if.master        bus,
  output logic                        ocupado,
  output logic                        pronto,
  output logic [3:0]                  db_indice,
  output logic [3:0]                  db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    INICIO  = 3'd1,
    BIT     = 3'd2,
    PARADA  = 3'd3,
    ESPERA  = 3'd4,
    PROXIMO = 3'd5,
    ATRASO  = 3'd6,
    PRONTO  = 3'd7
  } estado_t;

`ifdef OV7670_SOFT_RESET_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DELAY_CYCLES - 1);
  localparam logic [3:0]    LAST = 4'(N - 1);

  function automatic logic [15:0] entry(input logic [3:0] i);
    logic [3:0] k;
`ifdef OV7670_SOFT_RESET_EN
    k = i - 4'd1;
`else
    k = i;
`endif
    case (k)
      4'd0:    entry = 16'h1214;
      4'd1:    entry = 16'h40D0;
      4'd2:    entry = 16'h1101;
      4'd3:    entry = 16'h3A04;
      4'd4:    entry = 16'h0C04;
      default: entry = 16'h3E00;
    endcase
`ifdef OV7670_SOFT_RESET_EN
    if (i == 4'd0) entry = 16'h1280;
`endif
  endfunction

  estado_t       state;
  estado_t       nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    q;
  logic [4:0]    bitn;
  logic [3:0]    idx;
  logic [DW-1:0] dly;

  logic        timed;
  logic        tick;
  logic        qend;
  logic        dly_done;
  logic        start_req;
  logic [15:0] cur;
  logic [26:0] word;
  logic        bitv;
  logic        sioc;
  logic        siod_oe;

  assign timed = (state == INICIO) || (state == BIT) ||
                 (state == PARADA) || (state == ESPERA);
  assign tick      = (cnt == CMAX);
  assign qend      = timed && tick && (q == 2'd3);
  assign dly_done  = (dly == DMAX);
  assign start_req = iniciar &&
                     ((state == OCIOSO) || (state == PRONTO));

  // Each phase: 8 data bits MSB first, then a released don't-care bit
  assign cur  = entry(idx);
  assign word = {8'h42, 1'b1, cur[15:8], 1'b1, cur[7:0], 1'b1};
  assign bitv = word[5'd26 - bitn];

  always_comb begin
    nxt = state;
    unique case (state)
      OCIOSO, PRONTO: if (iniciar) nxt = INICIO;
      INICIO:  if (qend) nxt = BIT;
      BIT:     if (qend && bitn == 5'd26) nxt = PARADA;
      PARADA:  if (qend) nxt = ESPERA;
      ESPERA:  if (qend) nxt = PROXIMO;
      PROXIMO: begin
        if (idx == LAST) nxt = PRONTO;
`ifdef OV7670_SOFT_RESET_EN
        else if (idx == 4'd0) nxt = ATRASO;
`endif
        else nxt = INICIO;
      end
      ATRASO:  if (dly_done) nxt = INICIO;
      default: nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= OCIOSO;
      cnt   <= '0;
      q     <= 2'd0;
      bitn  <= 5'd0;
      idx   <= 4'd0;
      dly   <= '0;
    end else begin
      state <= nxt;
      // divider only runs in the quarter-timed states, so it restarts at 0
      if (!timed || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (!timed) q <= 2'd0;
      else if (tick) q <= q + 2'd1;
      if (state != BIT) bitn <= 5'd0;
      else if (qend) bitn <= bitn + 5'd1;
      if (start_req) idx <= 4'd0;
      else if (state == PROXIMO && idx != LAST) idx <= idx + 4'd1;
      if (state != ATRASO) dly <= '0;
      else dly <= dly + 1'b1;
    end
  end

  always_comb begin
    sioc    = 1'b1;
    siod_oe = 1'b0;
    unique case (state)
      INICIO: begin
        sioc    = ~q[1];
        siod_oe = (q != 2'd0);
      end
      BIT: begin
        sioc    = q[1];
        siod_oe = ~bitv;
      end
      PARADA: begin
        sioc    = (q != 2'd0);
        siod_oe = ~q[1];
      end
      default: begin
        sioc    = 1'b1;
        siod_oe = 1'b0;
      end
    endcase
  end

  assign bus.sioc    = sioc;
  assign bus.siod_oe = siod_oe;
  assign ocupado     = (state != OCIOSO) && (state != PRONTO);
  assign pronto      = (state == PRONTO);
  assign db_indice   = idx;
  assign db_estado   = {1'b0, state};

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: randomized checks of the SCCB table sequencer
// against a bit-level model of the register table.
`timescale 1ns/1ps
module tb_ov7670_sccb_config;
  localparam int CLK_DIV = 4;
  localparam int DELAY   = 100;
  localparam int LIMIT   = 6000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_indice;
  logic [3:0] db_estado;

  ov7670_sccb_config_if bus ();

  ov7670_sccb_config #(
    .CLK_DIV      (CLK_DIV),
    .DELAY_CYCLES (DELAY)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .bus       (bus),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_indice (db_indice),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [15:0] tbl[$];
  bit          exp_bits[$];
  int          exp_n;

  bit   cap[$];
  int   xfer_len[$];
  int   starts, stops, bad_edges, cur_len;
  bit   in_xfer;
  bit   mon_rst = 1'b0;
  logic p_sioc = 1'b1;
  logic p_siod = 1'b1;

  int r_n, r_both, r_gap, r_maxidx, r_atr, r_atrbus;
  logic r_occ1, r_pr1;
  logic [3:0] r_idx1;

  // Bus monitor: captures SIOD on each SIOC rise, frames start/stop
  always @(negedge clock) begin
    logic s, d;
    s = bus.sioc;
    d = ~bus.siod_oe;
    if (mon_rst) begin
      cap.delete();
      xfer_len.delete();
      starts = 0;
      stops = 0;
      bad_edges = 0;
      cur_len = 0;
      in_xfer = 0;
    end else begin
      if (p_sioc === 1'b0 && s === 1'b1) begin
        cap.push_back(d);
        cur_len++;
      end
      if (p_sioc === 1'b1 && s === 1'b1 && d !== p_siod) begin
        if (d === 1'b0) begin
          if (in_xfer) bad_edges++;
          starts++;
          in_xfer = 1;
          cur_len = 0;
        end else begin
          if (!in_xfer) bad_edges++;
          stops++;
          in_xfer = 0;
          // last rise before a stop is the stop's own clock, not data
          if (cap.size() > 0) void'(cap.pop_back());
          xfer_len.push_back(cur_len - 1);
        end
      end
    end
    p_sioc = s;
    p_siod = d;
  end

  task automatic build_model();
    logic [15:0] e;
    logic [7:0]  b[3];
    tbl = {};
`ifdef OV7670_SOFT_RESET_EN
    tbl.push_back(16'h1280);
`endif
    tbl.push_back(16'h1214);
    tbl.push_back(16'h40D0);
    tbl.push_back(16'h1101);
    tbl.push_back(16'h3A04);
    tbl.push_back(16'h0C04);
    tbl.push_back(16'h3E00);
    exp_bits = {};
    foreach (tbl[i]) begin
      e = tbl[i];
      b[0] = 8'h42;
      b[1] = e[15:8];
      b[2] = e[7:0];
      for (int j = 0; j < 3; j++) begin
        for (int k = 7; k >= 0; k--) exp_bits.push_back(b[j][k]);
        exp_bits.push_back(1'b1);
      end
    end
    exp_n = tbl.size() * (120 * CLK_DIV + 1) + 1;
`ifdef OV7670_SOFT_RESET_EN
    exp_n += DELAY;
`endif
  endtask

  function automatic int stream_mism();
    int m;
    int len;
    m = (cap.size() > exp_bits.size()) ? cap.size() - exp_bits.size()
                                       : exp_bits.size() - cap.size();
    len = (cap.size() < exp_bits.size()) ? cap.size() : exp_bits.size();
    for (int i = 0; i < len; i++) if (cap[i] !== exp_bits[i]) m++;
    return m;
  endfunction

  task automatic clear_mon();
    mon_rst = 1;
    @(negedge clock);
    #1 mon_rst = 0;
  endtask

  task automatic run_table(input int poke_at);
    int n;
    clear_mon();
    repeat ($urandom_range(1, 5)) @(posedge clock);
    #1 iniciar = 1;
    @(posedge clock);
    #1 iniciar = 0;
    n = 1;
    r_occ1 = ocupado;
    r_pr1 = pronto;
    r_idx1 = db_indice;
    r_both = 0;
    r_gap = 0;
    r_maxidx = int'(db_indice);
    r_atr = 0;
    r_atrbus = 0;
    while (pronto !== 1'b1 && n < LIMIT) begin
      iniciar = (poke_at != 0 && n == poke_at);
      @(posedge clock);
      #1 n++;
      if (ocupado && pronto) r_both++;
      if (!ocupado && !pronto) r_gap++;
      if (int'(db_indice) > r_maxidx) r_maxidx = int'(db_indice);
      if (db_estado == 4'd6) begin
        r_atr++;
        if (bus.sioc !== 1'b1 || bus.siod_oe !== 1'b0) r_atrbus++;
      end
    end
    iniciar = 0;
    r_n = n;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clock);
    #1;
    if (bus.sioc !== 1'b1 || bus.siod_oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus got sioc=%b oe=%b want 1 0",
               bus.sioc, bus.siod_oe);
    end
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got ocupado=%b pronto=%b want 0 0",
               ocupado, pronto);
    end
    checks++;
    if (db_estado !== 4'd0 || db_indice !== 4'd0) begin
      failures++;
      $display("FAIL reset_dbg got estado=%0d indice=%0d want 0 0",
               db_estado, db_indice);
    end
    checks++;
    reset = 1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_full_run();
    int badlen;
    run_table(0);
    if (r_occ1 !== 1'b1) begin
      failures++;
      $display("FAIL ocupado_next got %b want 1", r_occ1);
    end
    checks++;
    if (r_n != exp_n) begin
      failures++;
      $display("FAIL pronto_latency got %0d want %0d", r_n, exp_n);
    end
    checks++;
    if (r_both != 0 || r_gap != 0) begin
      failures++;
      $display("FAIL busy_flags got both=%0d gap=%0d want 0 0", r_both, r_gap);
    end
    checks++;
    if (starts != tbl.size() || stops != tbl.size() || bad_edges != 0) begin
      failures++;
      $display("FAIL start_stop got %0d/%0d bad=%0d want %0d/%0d bad=0",
               starts, stops, bad_edges, tbl.size(), tbl.size());
    end
    checks++;
    badlen = 0;
    foreach (xfer_len[i]) if (xfer_len[i] != 27) badlen++;
    if (badlen != 0 || xfer_len.size() != tbl.size()) begin
      failures++;
      $display("FAIL bits_per_xfer got %0d bad of %0d want 0 of %0d",
               badlen, xfer_len.size(), tbl.size());
    end
    checks++;
  endtask

  task automatic test_decode();
    logic [7:0] a, r, v;
    logic [2:0] dc;
    logic [15:0] e;
    run_table(0);
    a = 8'hxx;
    r = 8'hxx;
    v = 8'hxx;
    dc = 3'bxxx;
    if (cap.size() >= 27) begin
      for (int i = 0; i < 8; i++) begin
        a[7-i] = cap[i];
        r[7-i] = cap[9+i];
        v[7-i] = cap[18+i];
      end
      dc = {cap[8], cap[17], cap[26]};
    end
    e = tbl[0];
    if (a !== 8'h42) begin
      failures++;
      $display("FAIL dev_addr got %h want 42", a);
    end
    checks++;
    if (r !== e[15:8] || v !== e[7:0]) begin
      failures++;
      $display("FAIL first_entry got %h=%h want %h=%h", r, v, e[15:8], e[7:0]);
    end
    checks++;
    if (dc !== 3'b111) begin
      failures++;
      $display("FAIL dont_care got %b want 111", dc);
    end
    checks++;
    if (stream_mism() != 0) begin
      failures++;
      $display("FAIL bitstream got %0d bad bits of %0d want 0",
               stream_mism(), exp_bits.size());
    end
    checks++;
  endtask

  task automatic test_soft_reset();
    run_table(0);
`ifdef OV7670_SOFT_RESET_EN
    if (cap.size() < 27 || {cap[9], cap[10], cap[11], cap[12], cap[13],
        cap[14], cap[15], cap[16]} !== 8'h12 ||
        {cap[18], cap[19], cap[20], cap[21], cap[22], cap[23], cap[24],
         cap[25]} !== 8'h80) begin
      failures++;
      $display("FAIL soft_reset_entry got %0d bits want 12=80 first",
               cap.size());
    end
    checks++;
    if (r_atr != DELAY || r_atrbus != 0) begin
      failures++;
      $display("FAIL atraso got %0d cycles busy=%0d want %0d busy=0",
               r_atr, r_atrbus, DELAY);
    end
    checks++;
    if (r_maxidx != 6) begin
      failures++;
      $display("FAIL max_indice got %0d want 6", r_maxidx);
    end
    checks++;
`else
    if (r_atr != 0) begin
      failures++;
      $display("FAIL atraso got %0d cycles want 0", r_atr);
    end
    checks++;
    if (r_maxidx != 5) begin
      failures++;
      $display("FAIL max_indice got %0d want 5", r_maxidx);
    end
    checks++;
`endif
  endtask

  task automatic test_busy();
    int p;
    p = $urandom_range(20, 440);
    run_table(p);
    if (r_n != exp_n) begin
      failures++;
      $display("FAIL busy_latency poke=%0d got %0d want %0d", p, r_n, exp_n);
    end
    checks++;
    if (stream_mism() != 0 || starts != tbl.size()) begin
      failures++;
      $display("FAIL busy_stream got %0d bad starts=%0d want 0 starts=%0d",
               stream_mism(), starts, tbl.size());
    end
    checks++;
  endtask

  task automatic test_restart();
    if (pronto !== 1'b1) begin
      failures++;
      $display("FAIL pronto_hold got %b want 1", pronto);
    end
    checks++;
    run_table(0);
    if (r_pr1 !== 1'b0 || r_idx1 !== 4'd0 || r_occ1 !== 1'b1) begin
      failures++;
      $display("FAIL restart got pronto=%b idx=%0d ocupado=%b want 0 0 1",
               r_pr1, r_idx1, r_occ1);
    end
    checks++;
    if (r_n != exp_n || stream_mism() != 0) begin
      failures++;
      $display("FAIL rerun got n=%0d bad=%0d want n=%0d bad=0",
               r_n, stream_mism(), exp_n);
    end
    checks++;
  endtask

  task automatic test_mid_reset();
    int k;
    clear_mon();
    @(posedge clock);
    #1 iniciar = 1;
    @(posedge clock);
    #1 iniciar = 0;
    k = 0;
    while (cap.size() < 10 && k < 2000) begin
      @(posedge clock);
      #1 k++;
    end
    if (k >= 2000) begin
      failures++;
      $display("FAIL reach_bit10 got %0d bits want 10", cap.size());
    end
    checks++;
    repeat ($urandom_range(0, 3)) @(posedge clock);
    #2 reset = 0;
    #1;
    if (bus.sioc !== 1'b1 || bus.siod_oe !== 1'b0 ||
        ocupado !== 1'b0 || pronto !== 1'b0 ||
        db_estado !== 4'd0 || db_indice !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got sioc=%b oe=%b oc=%b pr=%b st=%0d ix=%0d",
               bus.sioc, bus.siod_oe, ocupado, pronto, db_estado, db_indice);
    end
    checks++;
    repeat (3) @(posedge clock);
    #1 reset = 1;
    run_table(0);
    if (r_idx1 !== 4'd0 || r_n != exp_n || stream_mism() != 0) begin
      failures++;
      $display("FAIL after_reset got idx=%0d n=%0d bad=%0d want 0 %0d 0",
               r_idx1, r_n, stream_mism(), exp_n);
    end
    checks++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    test_reset();
    test_full_run();
    test_decode();
    test_soft_reset();
    test_busy();
    test_restart();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
